// File: rtl/rr_arb_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_mux_pkg
//   Shared definitions for the arbitrating multiplexer slice:
//     - PRIO_RR / PRIO_FIXED : encodings of the prio_mode input
//     - clog2()              : constant ceil(log2()) helper
//     - sel_width()          : width of a channel index for a given channel count
// -----------------------------------------------------------------------------
package rr_arb_mux_pkg;

  // prio_mode encodings
  localparam logic PRIO_RR    = 1'b0;  // round-robin starting at rr_ptr
  localparam logic PRIO_FIXED = 1'b1;  // lowest requesting index wins

  // ceil(log2(value)); 0 for value <= 1
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Channel index width. Kept at least one bit so index vectors are never empty.
  function automatic int sel_width(input int num_in);
    return (clog2(num_in) < 1) ? 1 : clog2(num_in);
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// -----------------------------------------------------------------------------
// rr_arb_mux_if
//   Bundles the N input channels and the single output stage of rr_arb_mux.
//   Parameters:
//     WIDTH  : data bits per channel
//     NUM_IN : number of input channels
//   Signals:
//     in_data   [NUM_IN*WIDTH] packed channel data, channel i at [i*WIDTH +: WIDTH]
//     in_valid  [NUM_IN]       per-channel request
//     in_ready  [NUM_IN]       per-channel accept (at most one bit set)
//     out_data  [WIDTH]        registered selected word
//     out_sel   [SEL_W]        channel that supplied out_data
//     out_valid                output register holds a word
//     out_ready                consumer accepts the word
//   Modports:
//     slave  : the arbiter itself
//     master : the surrounding producers/consumer
// -----------------------------------------------------------------------------
interface rr_arb_mux_if
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 8
) ();

  localparam int SEL_W = sel_width(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_sel,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_sel,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/rr_arb_mux_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
//   Purely combinational round-robin / fixed-priority grant.
//   Ports:
//     req       [NUM_IN] in   request vector
//     base      [SEL_W]  in   round-robin start index (0..NUM_IN-1)
//     mode               in   PRIO_RR or PRIO_FIXED
//     grant     [NUM_IN] out  one-hot grant, all-zero when nothing requests
//     grant_idx [SEL_W]  out  encoded index of the granted channel (0 if none)
//     grant_any          out  some channel is granted
//
//   The request vector is doubled ({req, req}) so that the window starting at
//   the base index is a plain slice: bit i of that window is channel
//   (base + i) mod NUM_IN. A lowest-set-bit search over the window gives the
//   offset from base; adding it back and folding once yields the channel.
//   Fixed priority is just the same search with base forced to zero.
// -----------------------------------------------------------------------------
module rr_grant
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_IN = 8
) (
  input  logic [NUM_IN-1:0]               req,
  input  logic [sel_width(NUM_IN)-1:0]    base,
  input  logic                            mode,
  output logic [NUM_IN-1:0]               grant,
  output logic [sel_width(NUM_IN)-1:0]    grant_idx,
  output logic                            grant_any
);

  localparam int SEL_W = sel_width(NUM_IN);

  logic [2*NUM_IN-1:0] req_dbl;
  logic [NUM_IN-1:0]   req_rot;
  logic [SEL_W-1:0]    eff_base;
  logic [SEL_W-1:0]    offset;
  logic                found;
  logic [SEL_W:0]      idx_sum;

  assign req_dbl  = {req, req};
  assign eff_base = (mode == PRIO_FIXED) ? '0 : base;

  // Rotated request window: req_rot[i] is channel (eff_base + i) mod NUM_IN.
  // eff_base + i never exceeds 2*NUM_IN-2, so it always lands in req_dbl.
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_rot
      logic [SEL_W:0] pos;
      assign pos         = {1'b0, eff_base} + (SEL_W+1)'(gi);
      assign req_rot[gi] = req_dbl[pos];
    end
  endgenerate

  // Lowest set bit of the window = distance from base to the winner.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && req_rot[i]) begin
        found  = 1'b1;
        offset = SEL_W'(i);
      end
    end
  end

  // Winner index: base + offset folded back into 0..NUM_IN-1 (one
  // subtraction suffices because both terms are below NUM_IN).
  assign idx_sum = {1'b0, eff_base} + {1'b0, offset};

  always_comb begin
    grant_idx = '0;
    if (found) begin
      if (idx_sum >= (SEL_W+1)'(NUM_IN)) begin
        grant_idx = SEL_W'(idx_sum - (SEL_W+1)'(NUM_IN));
      end else begin
        grant_idx = SEL_W'(idx_sum);
      end
    end
  end

  assign grant_any = found;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_onehot
      assign grant[gi] = found && (grant_idx == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
//   N-input, WIDTH-bit arbitrating multiplexer with a registered single-entry
//   output stage. One requesting channel is accepted per cycle (round-robin
//   or fixed priority) and its word appears on the output one cycle later.
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     prio_mode  in   PRIO_RR (round-robin) or PRIO_FIXED (lowest index wins)
//     bus        slave modport of rr_arb_mux_if (channel and output handshakes)
//
//   A new word may be loaded whenever the output register is empty or being
//   drained this cycle (load_en), which gives one word per cycle of sustained
//   throughput. out_ready reaches in_ready combinationally through load_en;
//   out_data only ever comes from the register.
// -----------------------------------------------------------------------------
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         prio_mode,
  rr_arb_mux_if.slave  bus
);

  localparam int SEL_W = sel_width(NUM_IN);

  // Output stage and round-robin pointer
  logic [WIDTH-1:0] out_data_reg,  out_data_next;
  logic [SEL_W-1:0] out_sel_reg,   out_sel_next;
  logic             out_valid_reg, out_valid_next;
  logic [SEL_W-1:0] rr_ptr_reg,    rr_ptr_next;

  // Arbitration
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_any;
  logic              load_en;
  logic              xfer;

  logic [WIDTH-1:0]  ch_data [NUM_IN];

  // Unpack the channel bus so the selected word is a simple array read.
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_grant #(
    .NUM_IN (NUM_IN)
  ) u_grant (
    .req       (bus.in_valid),
    .base      (rr_ptr_reg),
    .mode      (prio_mode),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign load_en = !out_valid_reg || bus.out_ready;

  // rst_n gates the accept path directly: while reset is held the register
  // reads empty (load_en=1), yet no producer may believe it was accepted.
  assign xfer = rst_n && load_en && grant_any;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign bus.in_ready[gi] = rst_n && load_en && grant[gi];
    end
  endgenerate

  always_comb begin
    out_data_next  = out_data_reg;
    out_sel_next   = out_sel_reg;
    out_valid_next = out_valid_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (xfer) begin
      // Covers both load-into-empty and drain-plus-load in the same cycle.
      out_data_next  = ch_data[grant_idx];
      out_sel_next   = grant_idx;
      out_valid_next = 1'b1;
      // Pointer follows the winner in both modes so a later switch to
      // round-robin continues fairly from the last served channel.
      rr_ptr_next    = (grant_idx == SEL_W'(NUM_IN-1)) ? '0 : grant_idx + 1'b1;
    end else if (bus.out_ready) begin
      // Drain with nothing to refill; data/sel keep their last values.
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else begin
      out_data_reg  <= out_data_next;
      out_sel_reg   <= out_sel_next;
      out_valid_reg <= out_valid_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_sel   = out_sel_reg;
  assign bus.out_valid = out_valid_reg;

  // Structural invariants of the arbiter.
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.in_ready));

  a_ptr_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    (int'(rr_ptr_reg) < NUM_IN));

  a_hold_on_stall : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_reg && !bus.out_ready) |=>
      (out_valid_reg && $stable(out_data_reg) && $stable(out_sel_reg)));

endmodule

// File: tb/tb_rr_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_mux
//   Drives an 8-channel and a 5-channel rr_arb_mux from the same stimulus
//   (the 5-channel one sees the low five channels). A behavioural model,
//   evaluated on every falling edge, predicts in_ready and the output stage
//   of both instances from the arbitration rules. Directed scenarios add
//   literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_rr_arb_mux;

  localparam int W  = 16;
  localparam int N8 = 8;
  localparam int N5 = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              prio_mode = 1'b0;
  logic              out_ready = 1'b0;
  logic [N8-1:0]     in_valid = '0;
  logic [N8*W-1:0]   in_data = '0;

  always #5 clk = ~clk;

  rr_arb_mux_if #(.WIDTH(W), .NUM_IN(N8)) bus8 ();
  rr_arb_mux_if #(.WIDTH(W), .NUM_IN(N5)) bus5 ();

  assign bus8.in_data   = in_data;
  assign bus8.in_valid  = in_valid;
  assign bus8.out_ready = out_ready;
  assign bus5.in_data   = in_data[N5*W-1:0];
  assign bus5.in_valid  = in_valid[N5-1:0];
  assign bus5.out_ready = out_ready;

  rr_arb_mux #(.WIDTH(W), .NUM_IN(N8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .prio_mode (prio_mode),
    .bus       (bus8.slave)
  );

  rr_arb_mux #(.WIDTH(W), .NUM_IN(N5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .prio_mode (prio_mode),
    .bus       (bus5.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: per instance, the held word and the next search start.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit           v;
    logic [W-1:0] d;
    int           s;
    int           ptr;
  } mstate_t;

  mstate_t m [2];

  // First requesting channel walking base, base+1, ... modulo n; -1 if none.
  function automatic int pick(input logic [N8-1:0] req, input int base, input int n);
    for (int j = 0; j < n; j++) begin
      int c;
      c = (base + j) % n;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int           n;
      int           g;
      bit           load;
      logic [63:0]  act_v, act_d, act_s, act_r, exp_r;
      string        tag;
      n     = (k == 0) ? N8 : N5;
      tag   = (k == 0) ? "n8" : "n5";
      act_v = (k == 0) ? 64'(bus8.out_valid) : 64'(bus5.out_valid);
      act_d = (k == 0) ? 64'(bus8.out_data)  : 64'(bus5.out_data);
      act_s = (k == 0) ? 64'(bus8.out_sel)   : 64'(bus5.out_sel);
      act_r = (k == 0) ? 64'(bus8.in_ready)  : 64'(bus5.in_ready);
      if (!rst_n) begin
        m[k].v = 1'b0; m[k].d = '0; m[k].s = 0; m[k].ptr = 0;
        check({tag, ".rst_valid"}, act_v, 64'd0);
        check({tag, ".rst_data"},  act_d, 64'd0);
        check({tag, ".rst_sel"},   act_s, 64'd0);
        check({tag, ".rst_ready"}, act_r, 64'd0);
      end else begin
        load  = !m[k].v || out_ready;
        g     = pick(in_valid, prio_mode ? 0 : m[k].ptr, n);
        exp_r = (load && g >= 0) ? (64'd1 << g) : 64'd0;
        check({tag, ".in_ready"},  act_r, exp_r);
        check({tag, ".out_valid"}, act_v, 64'(m[k].v));
        check({tag, ".out_data"},  act_d, 64'(m[k].d));
        check({tag, ".out_sel"},   act_s, 64'(m[k].s));
        if (load && g >= 0) begin
          m[k].v   = 1'b1;
          m[k].d   = in_data[g*W +: W];
          m[k].s   = g;
          m[k].ptr = (g + 1) % n;
          $display("[%0t] %s accept ch%0d data=0x%04h mode=%0d", $time, tag, g, m[k].d, prio_mode);
        end else if (out_ready) begin
          m[k].v = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Returns at posedge+1 of the first cycle with reset released.
  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] val);
    in_data[ch*W +: W] = val;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq_a [4];
    logic [7:0] seq_b [4];

    // Power-on reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // --- 1. Asynchronous reset while holding a word --------------------------
    for (int i = 0; i < N8; i++) set_ch(i, 16'h0100 + 16'(i));
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("t1.held_valid", 64'(bus8.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1.async_valid", 64'(bus8.out_valid), 64'd0);
    check("t1.async_data",  64'(bus8.out_data),  64'h0000);
    check("t1.async_ready", 64'(bus8.in_ready),  64'h00);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t1.first_ready", 64'(bus8.in_ready), 64'h01);
    @(posedge clk); #1;
    check("t1.first_sel", 64'(bus8.out_sel), 64'd0);

    // --- 2. Single channel ----------------------------------------------------
    in_valid = 8'b0010_0000;
    set_ch(5, 16'hA5A5);
    #1;
    check("t2.in_ready", 64'(bus8.in_ready), 64'h20);
    @(posedge clk); #1;
    check("t2.valid", 64'(bus8.out_valid), 64'd1);
    check("t2.data",  64'(bus8.out_data),  64'hA5A5);
    check("t2.sel",   64'(bus8.out_sel),   64'd5);

    // --- 3. Round-robin fairness from rr_ptr=0 --------------------------------
    do_reset();
    for (int i = 0; i < N8; i++) set_ch(i, 16'h1000 + 16'(i));
    in_valid  = 8'hFF;
    prio_mode = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("t3.sel",   64'(bus8.out_sel),   64'(i % N8));
      check("t3.valid", 64'(bus8.out_valid), 64'd1);
    end

    // --- 4. Skip/wrap, 8 channels then 5 channels -----------------------------
    seq_a = '{8'd1, 8'd7, 8'd1, 8'd7};
    seq_b = '{8'd0, 8'd4, 8'd0, 8'd4};
    do_reset();
    in_valid = 8'b1000_0010;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check("t4.sel8", 64'(bus8.out_sel), 64'(seq_a[i]));
    end
    do_reset();
    in_valid = 8'b0001_0001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check("t4.sel5", 64'(bus5.out_sel), 64'(seq_b[i]));
    end

    // --- 5. Fixed priority, then back to round-robin --------------------------
    @(posedge clk); #1;
    prio_mode = 1'b1;
    in_valid  = 8'hFF;
    #1;
    check("t5.ready", 64'(bus8.in_ready), 64'h01);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("t5.sel",   64'(bus8.out_sel),  64'd0);
      check("t5.ready", 64'(bus8.in_ready), 64'h01);
    end
    prio_mode = 1'b0;
    #1;
    check("t5.rr_ready", 64'(bus8.in_ready), 64'h02);
    @(posedge clk); #1;
    check("t5.rr_sel", 64'(bus8.out_sel), 64'd1);

    // --- 6. Backpressure then drain-plus-accept -------------------------------
    in_valid  = 8'b0000_0100;
    set_ch(2, 16'h1234);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 8'hFF;
    for (int i = 0; i < N8; i++) set_ch(i, 16'h2000 + 16'(i));
    set_ch(2, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6.stall_ready", 64'(bus8.in_ready),  64'h00);
      check("t6.stall_data",  64'(bus8.out_data),  64'h1234);
      check("t6.stall_valid", 64'(bus8.out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("t6.release_ready", 64'(bus8.in_ready), 64'h08);
    @(posedge clk); #1;
    check("t6.next_valid", 64'(bus8.out_valid), 64'd1);
    check("t6.next_sel",   64'(bus8.out_sel),   64'd3);
    check("t6.next_data",  64'(bus8.out_data),  64'h2003);

    // --- Randomized phase -----------------------------------------------------
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      prio_mode = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N8; i++) set_ch(i, 16'($urandom));
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-input, W-bit arbitrating multiplexer. Successor to the fixed 8:1 x16 combinational mux.
- Each input channel has a valid/ready handshake. A round-robin or fixed-priority arbiter picks one requesting channel per cycle.
- The selected word goes into a registered single-entry output stage that has its own valid/ready.
- Used wherever several producers share one 16-bit consumer, e.g. memory request or writeback sharing.

Parameters:
- WIDTH, 16, data width per channel in bits (>=1).
- NUM_IN, 8, number of input channels (>=2; powers of two are not required).
- SEL_W, derived localparam = clog2(NUM_IN), width of the channel index. Not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins). Sampled each cycle.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel request.
- in_ready  output  NUM_IN  per-channel accept (combinational).
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst_n low, takes effect immediately, independent of clk):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready=0 on all channels while reset is asserted.
  - Reset mid-transfer discards the held word; no partial state survives.
- load_en = !out_valid | out_ready.
- Grant (combinational), one-hot or zero:
  - Round-robin: first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_IN.
  - Fixed priority: lowest i with in_valid[i].
  - No valid input: grant=0.
- in_ready[i] = load_en & grant[i]. Never more than one bit set.
- Transfer on channel k occurs when in_valid[k] & in_ready[k]. At the next edge:
  - out_data <= in_data[k]; out_sel <= k; out_valid <= 1.
  - rr_ptr <= (k==NUM_IN-1) ? 0 : k+1. The pointer updates in both modes, so switching mode is glitch-free.
- Drain with no new transfer (out_valid & out_ready, grant=0): out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and accept in the same cycle: the new word loads and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Backpressure (out_valid & !out_ready): out_data, out_sel and out_valid hold stable; in_ready is all-zero; rr_ptr holds.
- Latency: 1 cycle from input accept to out_valid.
- rr_ptr wraps correctly for non-power-of-two NUM_IN and never holds a value >= NUM_IN.
- in_valid and in_data are not required to be stable before acceptance. The block only samples on an accept.
- No combinational path from out_ready to out_data. The out_ready to in_ready path is permitted.

Decomposition:
- Shared package: clog2 constant function; SEL_W derivation; mode encodings PRIO_RR=1'b0 and PRIO_FIXED=1'b1.
- Sub-module rr_grant(NUM_IN):
  - Inputs: req, base pointer, mode.
  - Output: one-hot grant plus encoded index.
  - Purely combinational, implemented as a double-width rotate/priority scheme.
- Top level holds the output register, rr_ptr and handshake logic.

Test Plan:
(All scenarios use NUM_IN=8, WIDTH=16.)
1. Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=16'h0000 and in_ready=8'h00 immediately, without waiting for a clk edge. After release, the first grant starts at ch0.
2. Single channel: in_valid=8'b0010_0000, ch5 data=16'hA5A5, out_ready=1 -> in_ready=8'b0010_0000 that cycle. Next cycle out_valid=1, out_data=16'hA5A5, out_sel=5.
3. Round-robin fairness: in_valid=8'hFF, prio_mode=0, out_ready=1 held, rr_ptr=0 -> out_sel sequence 0,1,2,...,7,0,1 on consecutive cycles with out_valid continuously 1.
4. Round-robin skip/wrap: in_valid=8'b1000_0010 -> out_sel sequence 1,7,1,7. Then NUM_IN=5, in_valid=5'b10001 -> sequence 0,4,0,4 (wrap correctness).
5. Fixed priority: prio_mode=1, in_valid=8'hFF -> out_sel=0 every cycle and in_ready=8'h01. Switching to prio_mode=0 after serving ch0 -> next out_sel=1.
6. Backpressure: out_valid=1 with out_data=16'h1234, out_ready=0 for 3 cycles, all in_valid=1 -> out_data stays 16'h1234 and in_ready=8'h00. Then raise out_ready=1 -> the word is drained and the next channel is accepted in the same cycle; out_valid stays 1.
